host_cmd_master: RTL and testbench

HOST_CMD_MASTER -- requirements
Module: host_cmd_master

---
 rtl/host_cmd_master.sv | 273 +++++++++++++++++++++++++++
 tb/tb_host_cmd_master.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_cmd_master.sv
// host_cmd_master
//   Issues host commands to a monitor core over an 8N1 UART link and collects
//   the zero-terminated response stream of op 1.
//
//   Optional feature: define HOST_CMD_TIMEOUT_EN to abandon a response that
//   goes quiet for TIMEOUT cycles (err pulse, back to IDLE). Without it the
//   response phase waits forever and err only flags op 0.
//
//   Ports
//     clk, resetn            clock, synchronous active-low reset
//     cmd_valid/ready/op/arg command handshake (op 1..7, 32-bit argument)
//     data_valid/ready/byte  payload bytes for op 5 / op 7
//     resp_valid/byte/last   one strobe per op 1 response byte, last on 0x00
//     busy, err              not-IDLE flag, one-cycle error pulse
//     uart_tx, uart_rx       serial link to the monitor core (idle high)
module host_cmd_master #(
  parameter int FREQ    = 50_000_000,
  parameter int BAUD    = 2_000_000,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_arg,
  input  logic        data_valid,
  output logic        data_ready,
  input  logic [7:0]  data_byte,
  output logic        resp_valid,
  output logic [7:0]  resp_byte,
  output logic        resp_last,
  output logic        busy,
  output logic        err,
  output logic        uart_tx,
  input  logic        uart_rx
);
  localparam int BT = FREQ / BAUD;
  localparam int CW = $clog2(BT + 1);

  typedef enum logic [2:0] {S_IDLE, S_OP, S_ARG, S_PAYLOAD, S_RESP} state_e;

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] arg_q, arg_d;      // next argument byte always sits in [31:24]
  logic [2:0]  nargs_q, nargs_d;
  logic [23:0] len_q, len_d;      // op 7 bytes still to forward
  logic        zero_q, zero_d;    // op 5 terminator accepted
  logic        err_q, err_d;
  logic        resp_valid_q, resp_valid_d;
  logic [7:0]  resp_byte_q, resp_byte_d;
  logic        resp_last_q, resp_last_d;
  logic        payload_done;

  // transmitter
  logic          tx_active_q;
  logic [9:0]    tx_shift_q;
  logic [3:0]    tx_bit_q;
  logic [CW-1:0] tx_cnt_q;
  logic          tx_load, tx_last, tx_free;
  logic [7:0]    tx_byte;

  // receiver
  logic          rx_s1_q, rx_s2_q, rx_s3_q, rx_active_q;
  logic [CW-1:0] rx_cnt_q;
  logic [3:0]    rx_idx_q;
  logic [7:0]    rx_shift_q;
  logic          rx_good;

`ifdef HOST_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_q, to_d;
`endif

  // A new frame may be loaded on the last cycle of the stop bit so that
  // consecutive frames follow each other with no idle gap.
  assign tx_last = tx_active_q && (tx_bit_q == 4'd9) && (tx_cnt_q == CW'(BT - 1));
  assign tx_free = !tx_active_q || tx_last;
  assign uart_tx = tx_active_q ? tx_shift_q[0] : 1'b1;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tx_active_q <= 1'b0;
      tx_shift_q  <= '1;
      tx_bit_q    <= '0;
      tx_cnt_q    <= '0;
    end else if (tx_load) begin
      tx_active_q <= 1'b1;
      tx_shift_q  <= {1'b1, tx_byte, 1'b0};
      tx_bit_q    <= '0;
      tx_cnt_q    <= '0;
    end else if (tx_active_q) begin
      if (tx_cnt_q == CW'(BT - 1)) begin
        tx_cnt_q   <= '0;
        tx_shift_q <= {1'b1, tx_shift_q[9:1]};
        tx_bit_q   <= tx_bit_q + 4'd1;
        if (tx_bit_q == 4'd9) tx_active_q <= 1'b0;
      end else begin
        tx_cnt_q <= tx_cnt_q + CW'(1);
      end
    end
  end

  // rx_idx 0 = start bit (re-checked mid-bit to reject glitches),
  // 1..8 = data LSB first, 9 = stop bit.
  assign rx_good = rx_active_q && (rx_cnt_q == '0) && (rx_idx_q == 4'd9) && rx_s2_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_s3_q     <= 1'b1;
      rx_active_q <= 1'b0;
      rx_cnt_q    <= '0;
      rx_idx_q    <= '0;
      rx_shift_q  <= '0;
    end else begin
      rx_s1_q <= uart_rx;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
      if (!rx_active_q) begin
        if (rx_s3_q && !rx_s2_q) begin
          rx_active_q <= 1'b1;
          rx_cnt_q    <= CW'(BT / 2 - 1);
          rx_idx_q    <= '0;
        end
      end else if (rx_cnt_q != '0) begin
        rx_cnt_q <= rx_cnt_q - CW'(1);
      end else begin
        rx_cnt_q <= CW'(BT - 1);
        rx_idx_q <= rx_idx_q + 4'd1;
        if (rx_idx_q == 4'd0) begin
          if (rx_s2_q) rx_active_q <= 1'b0;
        end else if (rx_idx_q == 4'd9) begin
          rx_active_q <= 1'b0;
        end else begin
          rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      arg_q        <= '0;
      nargs_q      <= '0;
      len_q        <= '0;
      zero_q       <= 1'b0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_byte_q  <= '0;
      resp_last_q  <= 1'b0;
`ifdef HOST_CMD_TIMEOUT_EN
      to_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      arg_q        <= arg_d;
      nargs_q      <= nargs_d;
      len_q        <= len_d;
      zero_q       <= zero_d;
      err_q        <= err_d;
      resp_valid_q <= resp_valid_d;
      resp_byte_q  <= resp_byte_d;
      resp_last_q  <= resp_last_d;
`ifdef HOST_CMD_TIMEOUT_EN
      to_q         <= to_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    arg_d        = arg_q;
    nargs_d      = nargs_q;
    len_d        = len_q;
    zero_d       = zero_q;
    err_d        = 1'b0;
    resp_valid_d = 1'b0;
    resp_byte_d  = resp_byte_q;
    resp_last_d  = 1'b0;
    tx_load      = 1'b0;
    tx_byte      = arg_q[31:24];
    cmd_ready    = 1'b0;
    data_ready   = 1'b0;
    payload_done = (op_q == 3'd5) ? zero_q : (len_q == '0);
`ifdef HOST_CMD_TIMEOUT_EN
    to_d         = '0;
`endif
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d   = cmd_op;
          len_d  = cmd_arg[23:0];
          zero_d = 1'b0;
          if (cmd_op == 3'd0) err_d = 1'b1;
          else state_d = S_OP;
          // Pre-align the argument so the first byte to send is on top.
          case (cmd_op)
            3'd2:    begin nargs_d = 3'd4; arg_d = cmd_arg;                 end
            3'd4:    begin nargs_d = 3'd2; arg_d = {cmd_arg[15:0], 16'h0}; end
            3'd6:    begin nargs_d = 3'd1; arg_d = {cmd_arg[7:0], 24'h0};  end
            3'd7:    begin nargs_d = 3'd3; arg_d = {cmd_arg[23:0], 8'h0};  end
            default: begin nargs_d = 3'd0; arg_d = cmd_arg;                 end
          endcase
        end
      end
      S_OP: begin
        if (tx_free) begin
          tx_load = 1'b1;
          tx_byte = {5'd0, op_q};
          state_d = S_ARG;
        end
      end
      S_ARG: begin
        if (nargs_q != 3'd0) begin
          if (tx_free) begin
            tx_load = 1'b1;
            arg_d   = {arg_q[23:0], 8'h00};
            nargs_d = nargs_q - 3'd1;
          end
        end else if (!tx_active_q) begin
          case (op_q)
            3'd1:    state_d = S_RESP;
            3'd5:    state_d = S_PAYLOAD;
            3'd7:    state_d = (len_q == '0) ? S_IDLE : S_PAYLOAD;
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_PAYLOAD: begin
        data_ready = !tx_active_q && !payload_done;
        if (data_ready && data_valid) begin
          tx_load = 1'b1;
          tx_byte = data_byte;
          if (op_q == 3'd5 && data_byte == 8'h00) zero_d = 1'b1;
          if (op_q == 3'd7) len_d = len_q - 24'd1;
        end else if (payload_done && !tx_active_q) begin
          state_d = S_IDLE;
        end
      end
      S_RESP: begin
        if (rx_good) begin
          resp_valid_d = 1'b1;
          resp_byte_d  = rx_shift_q;
          resp_last_d  = (rx_shift_q == 8'h00);
          if (rx_shift_q == 8'h00) state_d = S_IDLE;
        end
`ifdef HOST_CMD_TIMEOUT_EN
        to_d = to_q + TW'(1);
        if (rx_good) begin
          to_d = '0;
        end else if (to_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy       = (state_q != S_IDLE);
  assign err        = err_q;
  assign resp_valid = resp_valid_q;
  assign resp_byte  = resp_byte_q;
  assign resp_last  = resp_last_q;
endmodule

// File: tb/tb_host_cmd_master.sv
// tb_host_cmd_master
//   Drives randomized commands into host_cmd_master, decodes uart_tx with a
//   line-level UART receiver, plays monitor-core responses onto uart_rx and
//   compares everything against frame lists computed from the command rules.
module tb_host_cmd_master;
  localparam int BT    = 25;
  localparam int FRAME = 10 * BT;

  logic        clk = 1'b0, resetn = 1'b0;
  logic        cmd_valid = 1'b0, data_valid = 1'b0, uart_rx = 1'b1;
  logic [2:0]  cmd_op = '0;
  logic [31:0] cmd_arg = '0;
  logic [7:0]  data_byte = '0;
  logic        cmd_ready, data_ready, resp_valid, resp_last, busy, err, uart_tx;
  logic [7:0]  resp_byte;

  int checks = 0, errors = 0, cyc = 0;
  int dr_viol = 0, stray_last = 0;

  logic [7:0] mon_q[$];
  int         mon_st_q[$];
  bit         mon_ok_q[$];
  bit         mon_busy = 1'b0;
  logic [7:0] mon_b;
  int         mon_st;
  bit         mon_ok;
  logic [7:0] rsp_q[$];
  bit         rsp_last_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] pl_q[$];

  host_cmd_master #(.FREQ(50_000_000), .BAUD(2_000_000), .TIMEOUT(1_000_000)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .data_valid(data_valid), .data_ready(data_ready), .data_byte(data_byte),
    .resp_valid(resp_valid), .resp_byte(resp_byte), .resp_last(resp_last),
    .busy(busy), .err(err), .uart_tx(uart_tx), .uart_rx(uart_rx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Line-level decoder of uart_tx: samples every bit in its middle.
  initial begin
    forever begin
      @(negedge clk);
      if (resetn === 1'b1 && uart_tx === 1'b0) begin
        mon_st = cyc; mon_busy = 1'b1;
        repeat (BT / 2) @(negedge clk);
        mon_ok = (uart_tx === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (BT) @(negedge clk);
          mon_b[i] = uart_tx;
        end
        repeat (BT) @(negedge clk);
        mon_ok = mon_ok && (uart_tx === 1'b1);
        mon_q.push_back(mon_b); mon_st_q.push_back(mon_st); mon_ok_q.push_back(mon_ok);
        mon_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      rsp_q.push_back(resp_byte); rsp_last_q.push_back(resp_last);
    end
    if (resp_last === 1'b1 && resp_valid !== 1'b1) stray_last++;
    if (data_ready === 1'b1 && mon_busy) dr_viol++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  function automatic int n_args(input logic [2:0] op);
    case (op)
      3'd2: return 4;
      3'd4: return 2;
      3'd6: return 1;
      3'd7: return 3;
      default: return 0;
    endcase
  endfunction

  // Expected command frames: opcode, then the low n_args bytes of arg, most significant first.
  task automatic build_exp(input logic [2:0] op, input logic [31:0] arg);
    exp_q.delete();
    exp_q.push_back({5'd0, op});
    for (int k = n_args(op) - 1; k >= 0; k--) exp_q.push_back(8'(arg >> (8 * k)));
  endtask

  task automatic clear_mon();
    mon_q.delete(); mon_st_q.delete(); mon_ok_q.delete();
    rsp_q.delete(); rsp_last_q.delete();
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [31:0] arg);
    int n;
    n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
    while (cmd_ready !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 3'($urandom); cmd_arg = $urandom;
  endtask

  task automatic wait_idle(input int budget, output int fall, output bit tmo);
    int n;
    n = 0; tmo = 1'b0;
    @(negedge clk);
    while (busy !== 1'b0) begin
      if (n >= budget) begin tmo = 1'b1; break; end
      @(negedge clk); n++;
    end
    fall = cyc;
  endtask

  task automatic feed_byte(input logic [7:0] b, output bit ok);
    int n;
    n = 0; ok = 1'b1;
    data_valid = 1'b1; data_byte = b;
    while (data_ready !== 1'b1) begin
      if (n >= 4000) begin ok = 1'b0; break; end
      @(negedge clk); n++;
    end
    @(negedge clk);
    data_valid = 1'b0; data_byte = 8'($urandom);
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0; repeat (BT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin uart_rx = b[i]; repeat (BT) @(negedge clk); end
    uart_rx = stop; repeat (BT) @(negedge clk);
    uart_rx = 1'b1; repeat (BT) @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready got %b want 1", cmd_ready); end
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL rst_uart_tx got %b want 1", uart_tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL rst_data_ready got %b want 0", data_ready); end
    checks++; if (resp_valid !== 1'b0 || resp_last !== 1'b0) begin errors++; $display("FAIL rst_resp got v%b l%b want 0 0", resp_valid, resp_last); end
    checks++; if (resp_byte !== 8'h00) begin errors++; $display("FAIL rst_resp_byte got %h want 00", resp_byte); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", err); end
    resetn = 1'b1;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1 || uart_tx !== 1'b1) begin errors++; $display("FAIL rst_release got rdy%b tx%b want 1 1", cmd_ready, uart_tx); end
    $display("reset done");
  endtask

  task automatic test_cmd(input logic [2:0] op, input logic [31:0] arg);
    int fall, n, lim;
    bit tmo;
    clear_mon(); build_exp(op, arg); n = exp_q.size();
    send_cmd(op, arg);
    wait_idle(20000, fall, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL cmd_idle op%0d busy got %b want 0", op, busy); end
    repeat (5) @(negedge clk);
    checks++; if (mon_q.size() != n) begin errors++; $display("FAIL cmd_frames op%0d got %0d want %0d", op, mon_q.size(), n); end
    lim = (mon_q.size() < n) ? mon_q.size() : n;
    for (int i = 0; i < lim; i++) begin
      checks++;
      if (mon_q[i] !== exp_q[i] || !mon_ok_q[i]) begin
        errors++; $display("FAIL cmd_byte op%0d #%0d got %h stop_ok %0d want %h", op, i, mon_q[i], mon_ok_q[i], exp_q[i]);
      end
    end
    for (int i = 1; i < mon_st_q.size(); i++) begin
      checks++;
      if (mon_st_q[i] - mon_st_q[i-1] != FRAME) begin
        errors++; $display("FAIL cmd_gap op%0d #%0d got %0d want %0d", op, i, mon_st_q[i] - mon_st_q[i-1], FRAME);
      end
    end
    if (mon_st_q.size() > 0) begin
      checks++;
      if (fall < mon_st_q[0] + n * FRAME || fall > mon_st_q[0] + n * FRAME + 3) begin
        errors++; $display("FAIL cmd_busy_end op%0d got %0d want %0d..%0d", op, fall - mon_st_q[0], n * FRAME, n * FRAME + 3);
      end
    end
    $display("cmd op%0d arg %08h frames %0d", op, arg, mon_q.size());
  endtask

  // pl_q holds the payload bytes (without the terminator).
  task automatic test_op5();
    int fall, nbad, lim, v0;
    bit tmo, ok;
    logic [31:0] arg;
    arg = $urandom;
    clear_mon(); build_exp(3'd5, arg);
    foreach (pl_q[i]) exp_q.push_back(pl_q[i]);
    exp_q.push_back(8'h00);
    nbad = 0; v0 = dr_viol;
    send_cmd(3'd5, arg);
    foreach (pl_q[i]) begin feed_byte(pl_q[i], ok); if (!ok) nbad++; end
    feed_byte(8'h00, ok); if (!ok) nbad++;
    wait_idle(20000, fall, tmo);
    checks++; if (tmo || nbad != 0) begin errors++; $display("FAIL op5_flow got timeout %0d stalled %0d want 0 0", tmo, nbad); end
    repeat (5) @(negedge clk);
    checks++; if (mon_q.size() != exp_q.size()) begin errors++; $display("FAIL op5_frames got %0d want %0d", mon_q.size(), exp_q.size()); end
    lim = (mon_q.size() < exp_q.size()) ? mon_q.size() : exp_q.size();
    for (int i = 0; i < lim; i++) begin
      checks++;
      if (mon_q[i] !== exp_q[i] || !mon_ok_q[i]) begin errors++; $display("FAIL op5_byte #%0d got %h want %h", i, mon_q[i], exp_q[i]); end
    end
    checks++; if (dr_viol != v0) begin errors++; $display("FAIL op5_data_ready_in_frame got %0d want 0", dr_viol - v0); end
    $display("cmd op5 payload %0d bytes frames %0d", pl_q.size(), mon_q.size());
  endtask

  // pl_q holds the bytes offered; only the first len may be sent.
  task automatic test_op7(input int len);
    int fall, nbad, lim, acc;
    bit tmo, ok;
    logic [31:0] arg;
    arg = {8'($urandom), 16'h0000, 8'(len)};
    clear_mon(); build_exp(3'd7, arg);
    for (int i = 0; i < len; i++) exp_q.push_back(pl_q[i]);
    nbad = 0;
    send_cmd(3'd7, arg);
    for (int i = 0; i < len; i++) begin feed_byte(pl_q[i], ok); if (!ok) nbad++; end
    wait_idle(20000, fall, tmo);
    checks++; if (tmo || nbad != 0) begin errors++; $display("FAIL op7_flow got timeout %0d stalled %0d want 0 0", tmo, nbad); end
    // The surplus byte is offered in IDLE and must never be taken.
    acc = 0;
    data_valid = 1'b1; data_byte = pl_q[len];
    repeat (30) begin @(negedge clk); if (data_ready !== 1'b0 || uart_tx !== 1'b1) acc++; end
    data_valid = 1'b0;
    checks++; if (acc != 0) begin errors++; $display("FAIL op7_extra_byte got %0d active cycles want 0", acc); end
    checks++; if (mon_q.size() != exp_q.size()) begin errors++; $display("FAIL op7_frames got %0d want %0d", mon_q.size(), exp_q.size()); end
    lim = (mon_q.size() < exp_q.size()) ? mon_q.size() : exp_q.size();
    for (int i = 0; i < lim; i++) begin
      checks++;
      if (mon_q[i] !== exp_q[i] || !mon_ok_q[i]) begin errors++; $display("FAIL op7_byte #%0d got %h want %h", i, mon_q[i], exp_q[i]); end
    end
    $display("cmd op7 len %0d frames %0d", len, mon_q.size());
  endtask

  // pl_q holds the response including the final 00; a bad-stop frame is
  // injected before index bad_pos (none when negative).
  task automatic test_resp(input int bad_pos);
    int fall, lim;
    bit tmo;
    clear_mon();
    send_cmd(3'd1, $urandom);
    rx_send(8'h5A, 1'b1);                  // arrives before RESP: ignored
    repeat (20) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL resp_wait busy got %b want 1", busy); end
    foreach (pl_q[i]) begin
      if (i == bad_pos) rx_send(8'($urandom), 1'b0);
      repeat ($urandom_range(0, BT)) @(negedge clk);
      rx_send(pl_q[i], 1'b1);
    end
    wait_idle(5000, fall, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL resp_idle busy got %b want 0", busy); end
    checks++; if (rsp_q.size() != pl_q.size()) begin errors++; $display("FAIL resp_count got %0d want %0d", rsp_q.size(), pl_q.size()); end
    lim = (rsp_q.size() < pl_q.size()) ? rsp_q.size() : pl_q.size();
    for (int i = 0; i < lim; i++) begin
      checks++;
      if (rsp_q[i] !== pl_q[i] || rsp_last_q[i] != (i == pl_q.size() - 1)) begin
        errors++; $display("FAIL resp_byte #%0d got %h last %0d want %h last %0d", i, rsp_q[i], rsp_last_q[i], pl_q[i], (i == pl_q.size() - 1));
      end
    end
    checks++; if (stray_last != 0) begin errors++; $display("FAIL resp_last_alone got %0d want 0", stray_last); end
    checks++; if (mon_q.size() != 1 || (mon_q.size() > 0 && mon_q[0] !== 8'h01)) begin errors++; $display("FAIL resp_tx_frames got %0d want 1 (01)", mon_q.size()); end
    $display("cmd op1 response %0d bytes bad_pos %0d", rsp_q.size(), bad_pos);
  endtask

  task automatic test_err_op0();
    int lows;
    clear_mon();
    send_cmd(3'd0, $urandom);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL op0_err got %b want 1", err); end
    checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL op0_idle got busy%b rdy%b want 0 1", busy, cmd_ready); end
    @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL op0_err_pulse got %b want 0", err); end
    lows = 0;
    repeat (40) begin @(negedge clk); if (uart_tx !== 1'b1) lows++; end
    checks++; if (lows != 0) begin errors++; $display("FAIL op0_no_uart got %0d low cycles want 0", lows); end
    $display("cmd op0 rejected");
  endtask

  task automatic test_reset_mid();
    int n, lows;
    clear_mon();
    send_cmd(3'd2, $urandom);
    n = 0;
    while (!mon_busy && n < 2000) begin @(negedge clk); n++; end
    checks++; if (!mon_busy) begin errors++; $display("FAIL rstmid_start got no frame want frame"); end
    repeat (3 * BT + 5) @(negedge clk);  // inside data bit 2
    resetn = 1'b0;
    @(negedge clk);
    checks++; if (uart_tx !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_in_reset got tx%b rdy%b busy%b want 1 1 0", uart_tx, cmd_ready, busy);
    end
    resetn = 1'b1;
    @(negedge clk);
    checks++; if (uart_tx !== 1'b1 || cmd_ready !== 1'b1) begin errors++; $display("FAIL rstmid_release got tx%b rdy%b want 1 1", uart_tx, cmd_ready); end
    lows = 0;
    repeat (300) begin @(negedge clk); if (uart_tx !== 1'b1 || busy !== 1'b0) lows++; end
    checks++; if (lows != 0) begin errors++; $display("FAIL rstmid_quiet got %0d active cycles want 0", lows); end
    clear_mon();
    $display("reset mid-frame done");
  endtask

  initial begin
    logic [2:0] ops[4];
    int len;
    ops[0] = 3'd2; ops[1] = 3'd3; ops[2] = 3'd4; ops[3] = 3'd6;
    test_reset();
    test_cmd(3'd2, 32'hA5A5A5A5);
    test_cmd(3'd4, 32'h00001203);
    for (int i = 0; i < 6; i++) test_cmd(ops[$urandom_range(0, 3)], $urandom);

    pl_q.delete(); pl_q.push_back(8'h41);
    test_op5();
    for (int r = 0; r < 2; r++) begin
      pl_q.delete();
      len = $urandom_range(0, 3);
      for (int i = 0; i < len; i++) pl_q.push_back(8'($urandom_range(1, 255)));
      test_op5();
    end

    pl_q.delete(); pl_q.push_back(8'h11); pl_q.push_back(8'h22); pl_q.push_back(8'h33); pl_q.push_back(8'h44);
    test_op7(3);
    pl_q.delete(); pl_q.push_back(8'h99);
    test_op7(0);
    for (int r = 0; r < 2; r++) begin
      pl_q.delete();
      len = $urandom_range(1, 4);
      for (int i = 0; i <= len; i++) pl_q.push_back(8'($urandom));
      test_op7(len);
    end

    pl_q.delete(); pl_q.push_back(8'h4E); pl_q.push_back(8'h45); pl_q.push_back(8'h53); pl_q.push_back(8'h00);
    test_resp(-1);
    for (int r = 0; r < 2; r++) begin
      pl_q.delete();
      len = $urandom_range(1, 4);
      for (int i = 0; i < len; i++) pl_q.push_back(8'($urandom_range(1, 255)));
      pl_q.push_back(8'h00);
      test_resp($urandom_range(0, len));
    end

    test_err_op0();
    test_reset_mid();
    test_cmd(3'd6, $urandom);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
